// File: rtl/counter_monitor_pkg.sv
// Shared types for the counter monitor: event codes carried through the
// event queue and the tracking FSM state encoding.
package counter_monitor_pkg;

  // Event codes as they appear on evt_type.
  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_WRAP    = 2'b01,
    EVT_ERR     = 2'b10,
    EVT_RESTART = 2'b11
  } evt_type_e;

  // Tracking FSM: IDLE waits for enable, TRACK compares successive samples.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam int EVT_TYPE_W = 2;

endpackage

// File: rtl/counter_monitor_fifo.sv
// First-word-fall-through event queue. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
// A push into a full queue is still accepted when a pop happens in the same
// cycle, because the freed slot is reused at that edge.
module counter_monitor_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         pop_fire;
  logic         push_fire;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are only observable behind a valid pointer pair.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Watches an upstream counter and reports wraps, restarts and sequence
// errors through a small event queue, alongside saturating statistics.
//
// Handshake: evt_valid is high whenever the queue holds an event; the head
// (evt_type/evt_value) is held stable until a rising clk edge where both
// evt_valid and evt_ready are high, which pops it. evt_ready may be high
// while evt_valid is low; nothing happens then.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [WIDTH-1:0] evt_value,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic             overflow
);

  localparam int QW = EVT_TYPE_W + WIDTH;

  state_e           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  evt_type_e        evt;
  logic             push;
  logic             pop_fire;
  logic [QW-1:0]    head_data;
  logic             q_full;
  logic             q_empty;

  // Classify the current sample against the previous one.
  always_comb begin
    evt      = EVT_NONE;
    expected = prev + 1'b1;
    if (state == ST_TRACK && en) begin
      if (cnt_in == expected) begin
        // Matching the successor of all-ones means the counter rolled over.
        if (cnt_in == '0) evt = EVT_WRAP;
      end else if (cnt_in == '0) begin
        evt = EVT_RESTART;
      end else begin
        evt = EVT_ERR;
      end
    end
  end

  assign push     = (evt != EVT_NONE);
  assign pop_fire = evt_ready && !q_empty;

  counter_monitor_fifo #(
    .W     (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({evt, cnt_in}),
    .pop       (evt_ready),
    .head_data (head_data),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign evt_valid = !q_empty;
  assign evt_type  = q_empty ? EVT_NONE : head_data[QW-1:WIDTH];
  assign evt_value = q_empty ? '0 : head_data[WIDTH-1:0];

  // Tracking FSM and previous-sample register; every enabled sample resyncs prev.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      prev  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            prev  <= cnt_in;
            state <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (en) prev  <= cnt_in;
          else    state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating statistics and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      wrap_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (evt == EVT_ERR && err_count != '1)   err_count  <= err_count + 1'b1;
      if (evt == EVT_WRAP && wrap_count != '1) wrap_count <= wrap_count + 1'b1;
      if (push && q_full && !pop_fire)         overflow   <= 1'b1;
    end
  end

endmodule
